// File: rtl/sw_mem_bridge_pkg.sv
// sw_mem_bridge_pkg: shared definitions for the software-register to memory bridge.
//   - op encodings carried in sw_cmd[1:0]
//   - sw_cmd field positions and hw_status bit positions
//   - FSM state encoding
// Optional feature macro used by the bridge: SW_MEM_BRIDGE_TIMEOUT_EN.
package sw_mem_bridge_pkg;

   typedef enum logic [1:0] {
      OpNop   = 2'b00,
      OpRead  = 2'b01,
      OpWrite = 2'b10,
      OpFill  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StIssue  = 2'b01,
      StWaitRd = 2'b10
   } state_e;

   // sw_cmd fields
   localparam int unsigned CmdOpLsb    = 0;
   localparam int unsigned CmdOpMsb    = 1;
   localparam int unsigned CmdBankLsb  = 4;
   localparam int unsigned CmdBankMsb  = 7;
   localparam int unsigned CmdCountLsb = 8;
   localparam int unsigned CmdCountMsb = 15;
   localparam int unsigned CmdToggle   = 31;

   // hw_status fields
   localparam int unsigned StatBusy    = 0;
   localparam int unsigned StatDone    = 1;
   localparam int unsigned StatErrBank = 2;
   localparam int unsigned StatErrTo   = 3;
   localparam int unsigned StatAck     = 4;
   localparam int unsigned StatRemLsb  = 8;
   localparam int unsigned StatRemMsb  = 15;
   localparam int unsigned StatCntLsb  = 16;
   localparam int unsigned StatCntMsb  = 31;

endpackage

// File: rtl/sw_mem_watchdog.sv
// sw_mem_watchdog: read-wait cycle counter for sw_mem_bridge (used only when
// SW_MEM_BRIDGE_TIMEOUT_EN is defined).
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   start       - counting enabled while high (bridge is waiting for read data)
//   clear       - synchronous counter clear (bridge not waiting)
//   expire      - high during the TIMEOUT_CYCLES-th consecutive cycle of start
module sw_mem_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;

   // cnt_q holds the number of waiting cycles already elapsed, so the check is
   // against TIMEOUT_CYCLES-1 to fire in the TIMEOUT_CYCLES-th cycle itself.
   assign expire = start && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (start && !expire) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/sw_mem_bridge.sv
// sw_mem_bridge: turns toggle-handshaked software register commands into banked
// memory read / write / fill transactions.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   sw_cmd                - [1:0] op, [7:4] bank, [15:8] fill count, [31] sequence toggle
//   sw_addr, sw_wdata     - word address and write data
//   hw_rdata              - last read data, zero-extended
//   hw_status             - [0] busy [1] done [2] err_bank [3] err_timeout [4] ack_toggle
//                           [15:8] remaining [31:16] op_count
//   mem_req/we/bank/addr/wdata, mem_gnt, mem_rvalid, mem_rdata - memory request port
// Define SW_MEM_BRIDGE_TIMEOUT_EN to add a read-wait timeout (sw_mem_watchdog).
module sw_mem_bridge
   import sw_mem_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned NUM_BANKS      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           sw_cmd,
   input  logic [31:0]           sw_addr,
   input  logic [31:0]           sw_wdata,
   output logic [31:0]           hw_rdata,
   output logic [31:0]           hw_status,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [BANK_W-1:0]     mem_bank,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [3:0]            bank_q, bank_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [15:0]           op_count_q, op_count_d;
   logic                  ack_q, ack_d;
   logic                  done_q, done_d;
   logic                  err_bank_q, err_bank_d;
   logic                  err_to;
   logic                  wd_expire;
   logic                  bank_bad;
   logic                  complete;

   assign bank_bad = (32'(bank_q) >= NUM_BANKS);

`ifdef SW_MEM_BRIDGE_TIMEOUT_EN
   logic err_to_d;
   logic waiting;

   assign waiting = (state_q == StWaitRd);

   sw_mem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .start (waiting),
      .clear (!waiting),
      .expire(wd_expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_to <= 1'b0;
      else        err_to <= err_to_d;
   end
`else
   assign wd_expire = 1'b0;
   assign err_to    = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      bank_d      = bank_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      remaining_d = remaining_q;
      op_count_d  = op_count_q;
      ack_d       = ack_q;
      done_d      = done_q;
      err_bank_d  = err_bank_q;
`ifdef SW_MEM_BRIDGE_TIMEOUT_EN
      err_to_d    = err_to;
`endif
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      complete    = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A toggle mismatch is a new command; while busy it simply waits here.
            if (sw_cmd[CmdToggle] != ack_q) begin
               state_d    = StIssue;
               op_d       = op_e'(sw_cmd[CmdOpMsb:CmdOpLsb]);
               bank_d     = sw_cmd[CmdBankMsb:CmdBankLsb];
               addr_d     = sw_addr[ADDR_WIDTH-1:0];
               wdata_d    = sw_wdata[DATA_WIDTH-1:0];
               ack_d      = sw_cmd[CmdToggle];
               done_d     = 1'b0;
               err_bank_d = 1'b0;
`ifdef SW_MEM_BRIDGE_TIMEOUT_EN
               err_to_d   = 1'b0;
`endif
               remaining_d = sw_cmd[CmdCountMsb:CmdCountLsb];
               if (op_d == OpFill && remaining_d == 8'd0) remaining_d = 8'd1;
            end
         end
         StIssue: begin
            if (op_q == OpNop) begin
               complete = 1'b1;
            end else if (bank_bad) begin
               err_bank_d = 1'b1;
               complete   = 1'b1;
            end else begin
               mem_req = 1'b1;
               mem_we  = (op_q != OpRead);
               if (mem_gnt) begin
                  unique case (op_q)
                     OpRead: state_d = StWaitRd;
                     OpFill: begin
                        addr_d      = addr_q + 1'b1;
                        remaining_d = remaining_q - 8'd1;
                        complete    = (remaining_q == 8'd1);
                     end
                     default: complete = 1'b1;
                  endcase
               end
            end
         end
         StWaitRd: begin
            if (mem_rvalid) begin
               rdata_d  = mem_rdata;
               complete = 1'b1;
            end else if (wd_expire) begin
`ifdef SW_MEM_BRIDGE_TIMEOUT_EN
               err_to_d = 1'b1;
`endif
               complete = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (complete) begin
         state_d    = StIdle;
         done_d     = 1'b1;
         op_count_d = op_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         op_q        <= OpNop;
         bank_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         remaining_q <= '0;
         op_count_q  <= '0;
         ack_q       <= 1'b0;
         done_q      <= 1'b0;
         err_bank_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         remaining_q <= remaining_d;
         op_count_q  <= op_count_d;
         ack_q       <= ack_d;
         done_q      <= done_d;
         err_bank_q  <= err_bank_d;
      end
   end

   assign mem_bank  = bank_q[BANK_W-1:0];
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign hw_rdata  = 32'(rdata_q);

   always_comb begin
      hw_status                        = '0;
      hw_status[StatBusy]              = (state_q != StIdle);
      hw_status[StatDone]              = done_q;
      hw_status[StatErrBank]           = err_bank_q;
      hw_status[StatErrTo]             = err_to;
      hw_status[StatAck]               = ack_q;
      hw_status[StatRemMsb:StatRemLsb] = remaining_q;
      hw_status[StatCntMsb:StatCntLsb] = op_count_q;
   end

endmodule

// File: tb/tb_sw_mem_bridge.sv
// Directed bench for sw_mem_bridge: write, read, fill with address wrap, bad bank,
// command queued during a fill, reset mid-fill, nop, and read-wait behaviour
// (timeout when SW_MEM_BRIDGE_TIMEOUT_EN is defined, indefinite wait otherwise).
module tb_sw_mem_bridge;

   logic        clk;
   logic        reset;
   logic [31:0] sw_cmd;
   logic [31:0] sw_addr;
   logic [31:0] sw_wdata;
   logic [31:0] hw_rdata;
   logic [31:0] hw_status;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_bank;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;
   int grants = 0;

   sw_mem_bridge #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (10),
      .NUM_BANKS     (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_cmd    (sw_cmd),
      .sw_addr   (sw_addr),
      .sw_wdata  (sw_wdata),
      .hw_rdata  (hw_rdata),
      .hw_status (hw_status),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_bank  (mem_bank),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_gnt   (mem_gnt),
      .mem_rvalid(mem_rvalid),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (reset && mem_req && mem_gnt) grants <= grants + 1;
   end

   function automatic logic [31:0] mkcmd(input logic [1:0] op, input logic [3:0] bank,
                                         input logic [7:0] cnt, input logic tog);
      return {tog, 15'd0, cnt, bank, 2'b00, op};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] fill_addr [4];
      fill_addr[0] = 10'h3FE; fill_addr[1] = 10'h3FF;
      fill_addr[2] = 10'h000; fill_addr[3] = 10'h001;

      reset = 1'b0; sw_cmd = '0; sw_addr = '0; sw_wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #2;
      chk("reset_status", hw_status, 32'h0);
      chk("reset_req", 32'(mem_req), 32'h0);
      chk("reset_rdata", hw_rdata, 32'h0);
      step(1);
      reset = 1'b1;

      // Write with grant held off for three cycles.
      sw_cmd = mkcmd(2'b10, 4'd1, 8'd0, 1'b1); sw_addr = 32'h5; sw_wdata = 32'hDEADBEEF;
      step(1);
      for (int i = 0; i < 3; i++) begin
         chk("wr_req", {28'd0, mem_req, mem_we, mem_bank}, 32'hD);
         chk("wr_addr", 32'(mem_addr), 32'h5);
         chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
         chk("wr_busy", hw_status, 32'h0000_0011);
         if (i == 2) mem_gnt = 1'b1;
         step(1);
      end
      mem_gnt = 1'b0;
      chk("wr_done", hw_status, 32'h0001_0012);
      chk("wr_idle_req", 32'(mem_req), 32'h0);
      chk("wr_grants", 32'(grants), 32'd1);

      // rvalid while idle must be ignored.
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      step(1);
      mem_rvalid = 1'b0;
      chk("stray_rvalid", hw_rdata, 32'h0);

      // Read, data returns in the fourth wait cycle.
      sw_cmd = mkcmd(2'b01, 4'd1, 8'd0, 1'b0); sw_addr = 32'h5; mem_gnt = 1'b1;
      step(1);
      chk("rd_req", {30'd0, mem_req, mem_we}, 32'h2);
      step(1);
      mem_gnt = 1'b0;
      chk("rd_wait", hw_status, 32'h0001_0001);
      step(3);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      step(1);
      mem_rvalid = 1'b0;
      chk("rd_data", hw_rdata, 32'hDEADBEEF);
      chk("rd_done", hw_status, 32'h0002_0002);

      // Fill of four words wrapping past the top of the bank.
      sw_cmd = mkcmd(2'b11, 4'd0, 8'd4, 1'b1); sw_addr = 32'h3FE; sw_wdata = 32'h11;
      mem_gnt = 1'b1;
      step(1);
      for (int i = 0; i < 4; i++) begin
         chk("fill_addr", 32'(mem_addr), 32'(fill_addr[i]));
         chk("fill_rem", 32'(hw_status[15:8]), 32'(4 - i));
         chk("fill_req", {29'd0, mem_req, mem_we, mem_wdata == 32'h11}, 32'h7);
         step(1);
      end
      mem_gnt = 1'b0;
      chk("fill_done", hw_status, 32'h0003_0012);
      chk("fill_grants", 32'(grants), 32'd6);

      // Bank out of range.
      sw_cmd = mkcmd(2'b10, 4'd7, 8'd0, 1'b0);
      step(1);
      chk("bank_noreq", 32'(mem_req), 32'h0);
      step(1);
      chk("bank_err", hw_status, 32'h0004_0006);
      chk("bank_grants", 32'(grants), 32'd6);

      // Toggle flipped during a fill: queued write starts right after completion.
      sw_cmd = mkcmd(2'b11, 4'd2, 8'd3, 1'b1); sw_addr = 32'h10; mem_gnt = 1'b1;
      step(1);
      sw_cmd = mkcmd(2'b10, 4'd3, 8'd0, 1'b0); sw_addr = 32'h20; sw_wdata = 32'hA5;
      chk("q_fill_addr", 32'(mem_addr), 32'h10);
      step(3);
      chk("q_fill_done", hw_status, 32'h0005_0012);
      step(1);
      chk("q_wr_addr", {20'd0, mem_bank, mem_addr}, {20'd0, 2'd3, 10'h20});
      chk("q_wr_busy", hw_status, 32'h0005_0001);
      step(1);
      chk("q_wr_done", hw_status, 32'h0006_0002);
      mem_gnt = 1'b0;

      // Reset mid-fill, pending toggle=1 command taken after release.
      sw_cmd = mkcmd(2'b11, 4'd1, 8'd8, 1'b1); sw_addr = 32'h0; sw_wdata = 32'h77;
      mem_gnt = 1'b1;
      step(3);
      chk("rst_pre_addr", 32'(mem_addr), 32'h2);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_req", 32'(mem_req), 32'h0);
      chk("rst_status", hw_status, 32'h0);
      chk("rst_rdata", hw_rdata, 32'h0);
      step(1);
      reset = 1'b1;
      step(1);
      chk("rst_reaccept", hw_status, 32'h0000_0811);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      step(8);
      chk("rst_fill_done", hw_status, 32'h0001_0012);
      mem_gnt = 1'b0;

      // Nop.
      sw_cmd = mkcmd(2'b00, 4'd0, 8'd0, 1'b0);
      step(1);
      chk("nop_busy", {31'd0, mem_req}, 32'h0);
      chk("nop_status", hw_status, 32'h0001_0001);
      step(1);
      chk("nop_done", hw_status, 32'h0002_0002);

      // Read with no rvalid.
      sw_cmd = mkcmd(2'b01, 4'd0, 8'd0, 1'b1); mem_gnt = 1'b1;
      step(2);
      mem_gnt = 1'b0;
`ifdef SW_MEM_BRIDGE_TIMEOUT_EN
      step(15);
      chk("to_still_wait", hw_status, 32'h0002_0011);
      step(1);
      chk("to_err", hw_status, 32'h0003_001A);
      chk("to_rdata", hw_rdata, 32'h0);
`else
      step(30);
      chk("nto_wait", hw_status, 32'h0002_0011);
      mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
      step(1);
      mem_rvalid = 1'b0;
      chk("nto_rdata", hw_rdata, 32'h0BADF00D);
      chk("nto_done", hw_status, 32'h0003_0012);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sw_mem_bridge.md
SW_MEM_BRIDGE -- requirements
Module: sw_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width (1..32); register-side data is zero-extended to 32 bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the memory word-address width per bank.
REQ-003 SHALL have parameter NUM_BANKS, default 4, meaning the number of memory banks (1..16); BANK_W = max(1, clog2(NUM_BANKS)).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the read-wait limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sw_cmd, input, 32 bits: [1:0] op (00 nop, 01 read, 10 write, 11 fill), [7:4] bank, [15:8] fill count, [31] sequence toggle.
REQ-008 SHALL have ports sw_addr and sw_wdata, input, 32 bits each: software-register address and write data.
REQ-009 SHALL have port hw_rdata, output, 32 bits: last read data.
REQ-010 SHALL have port hw_status, output, 32 bits: [0] busy, [1] done, [2] err_bank, [3] err_timeout, [4] ack_toggle, [15:8] remaining, [31:16] op_count.
REQ-011 SHALL have memory-side ports mem_req, mem_we (output, 1 bit), mem_bank (output, BANK_W), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_gnt, mem_rvalid (input, 1 bit) and mem_rdata (input, DATA_WIDTH).

Function
REQ-012 SHALL accept a command only in IDLE, and only when sw_cmd[31] != ack_toggle; accept latches op, bank, sw_addr[ADDR_WIDTH-1:0], sw_wdata[DATA_WIDTH-1:0] and count, copies sw_cmd[31] into ack_toggle, clears done and both err bits, and sets busy.
REQ-013 SHALL, on a toggle change while busy, not latch the command; the command is taken on the first IDLE cycle after completion (one-deep implicit queue).
REQ-014 SHALL complete op nop in one cycle with no memory access, setting done.
REQ-015 SHALL, when the accepted bank >= NUM_BANKS, issue no mem_req, set err_bank and done, and return to IDLE on the next cycle.
REQ-016 SHALL implement FSM states IDLE -> ISSUE -> (WAIT_RD for read) -> IDLE.
REQ-017 SHALL hold mem_req, mem_we, mem_bank, mem_addr and mem_wdata stable in ISSUE until the cycle mem_gnt=1.
REQ-018 SHALL, for a read, go from ISSUE to WAIT_RD on grant, capture mem_rdata into hw_rdata on mem_rvalid, then set done and return to IDLE.
REQ-019 SHALL, for a write, set done and return to IDLE on grant.
REQ-020 SHALL, for fill, write max(1,count) words: on each grant it increments mem_addr modulo 2^ADDR_WIDTH (wraps, no error) and decrements remaining, leaving ISSUE after the last grant.
REQ-021 SHALL increment op_count by 1 (wrapping at 16 bits) at every completion, including error completions.
REQ-022 SHALL drive mem_req, mem_we and busy to 0 in IDLE.
REQ-023 SHALL treat mem_rvalid outside WAIT_RD as ignored.

Reset
REQ-024 SHALL, on reset low, immediately force state IDLE, all outputs 0 and ack_toggle 0, including mid-operation, abandoning any outstanding request; a pending toggle=1 command is accepted on the first cycle after release.

Configuration
REQ-025 SHALL, with SW_MEM_BRIDGE_TIMEOUT_EN defined, count cycles in WAIT_RD and, at TIMEOUT_CYCLES without mem_rvalid, set err_timeout and done, leave hw_rdata unchanged, and return to IDLE.
REQ-026 SHALL, without SW_MEM_BRIDGE_TIMEOUT_EN, wait indefinitely in WAIT_RD, with hw_status[3] tied to 0 and no counter logic present.

Structure
REQ-027 SHALL place the op encodings, hw_status bit positions, sw_cmd field positions and the FSM state encoding in shared package sw_mem_bridge_pkg.
REQ-028 SHALL implement the timeout counter as sub-module sw_mem_watchdog (start, clear, expire), instantiated only under SW_MEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-029 SHALL cover: write bank 1 addr 0x005 data 0xDEADBEEF, toggle 1, mem_gnt delayed 3 cycles -> one grant with stable outputs, done=1, ack_toggle=1, op_count=1.
REQ-030 SHALL cover: read bank 1 addr 0x005, toggle 0, mem_rvalid with 0xDEADBEEF after 4 cycles -> hw_rdata=0xDEADBEEF, done=1.
REQ-031 SHALL cover: fill bank 0 addr 0x3FE count 4 data 0x11 -> writes to 0x3FE, 0x3FF, 0x000, 0x001, remaining steps 3/2/1/0.
REQ-032 SHALL cover: bank 7 with NUM_BANKS=4 -> no mem_req, err_bank=1, done=1.
REQ-033 SHALL cover: toggle flipped during a fill -> second command starts the cycle after the first completes; reset asserted mid-fill -> mem_req=0 immediately, status=0.
REQ-034 SHALL cover: with the macro defined and TIMEOUT_CYCLES=16, read with no rvalid -> err_timeout=1 at cycle 16, FSM in IDLE.
